// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller:
// operation codes, FSM state encoding and an operation-decode helper.
package hilo_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StWait   = 2'd2,
    StFinish = 2'd3
  } hilo_state_e;

  // Only MULT and DIV start an operation; NONE and the reserved code are dropped.
  function automatic logic op_is_valid(logic [1:0] op);
    logic valid;
    case (op)
      OP_MULT, OP_DIV:  valid = 1'b1;
      OP_NONE, OP_RSVD: valid = 1'b0;
      default:          valid = 1'b0;
    endcase
    return valid;
  endfunction

endpackage

// File: rtl/hilo_watchdog.sv
// WAIT-state watchdog for hilo_ctrl. Only instantiated when HILO_TIMEOUT_EN
// is defined. Counts consecutive enabled cycles and flags the last allowed
// one so the controller can abort on the following edge.
module hilo_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  output logic Expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count while enabled, restart from zero whenever the controller leaves WAIT.
  always_comb begin
    cnt_d = '0;
    if (Enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of WAIT cycles already completed before this one.
  assign Expired = Enable && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO controller: accepts MULT/DIV commands, launches the external unit,
// captures its results into the architectural HI/LO registers.
// Optional feature macro: HILO_TIMEOUT_EN (adds the WAIT watchdog and the
// Timeout port).
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  output logic        UnitStart,
  output logic        UnitSel,
  output logic [31:0] OpA,
  output logic [31:0] OpB,
  input  logic        UnitDone,
  input  logic [31:0] UnitHi,
  input  logic [31:0] UnitLo,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero
`ifdef HILO_TIMEOUT_EN
  ,
  output logic        Timeout
`endif
);

  hilo_state_e state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        sel_q, sel_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dz_q, dz_d;
  logic        wd_expired;

`ifdef HILO_TIMEOUT_EN
  logic to_q, to_d;

  hilo_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (state_q == StWait),
    .Expired(wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expired = 1'b0;
`endif

  // Next-state logic: command accept, launch, result capture, completion.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sel_d   = sel_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
`ifdef HILO_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      StIdle: begin
        if (Start && op_is_valid(Op)) begin
          op_a_d = RsData;
          op_b_d = RtData;
          sel_d  = Op[1];
          // A zero divisor never reaches the unit; report it straight away.
          dz_d   = (Op == OP_DIV) && (RtData == '0);
`ifdef HILO_TIMEOUT_EN
          to_d   = 1'b0;
`endif
          state_d = dz_d ? StFinish : StLaunch;
        end
      end
      StLaunch: begin
        state_d = StWait;
      end
      StWait: begin
        if (UnitDone) begin
          hi_d    = UnitHi;
          lo_d    = UnitLo;
          state_d = StFinish;
        end else if (wd_expired) begin
`ifdef HILO_TIMEOUT_EN
          to_d    = 1'b1;
`endif
          state_d = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sel_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
`ifdef HILO_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sel_q   <= sel_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
`ifdef HILO_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  // Status pulses decode from the state register, so reset clears them at once.
  always_comb begin
    UnitStart = (state_q == StLaunch);
    Busy      = (state_q != StIdle);
    Done      = (state_q == StFinish);
    DivZero   = (state_q == StFinish) && dz_q;
`ifdef HILO_TIMEOUT_EN
    Timeout   = (state_q == StFinish) && to_q;
`endif
  end

  assign UnitSel = sel_q;
  assign OpA     = op_a_q;
  assign OpB     = op_b_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule
